masked_subbytes_seq: RTL and testbench

MASKED_SUBBYTES_SEQ -- requirements
Module: masked_subbytes_seq

---
 rtl/masked_subbytes_seq.sv | 133 +++++++++++++
 tb/tb_masked_subbytes_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_subbytes_seq.sv
// Masked AES SubBytes sequencer: streams the 16 bytes of a Boolean-shared state through one shared S-box and writes results back in place.
// Latency: start at edge T, issue cycles T+1..T+16 (plus one per RandOKxSI stall), DonexSO in cycle T+17+LATENCY.
// Backpressure: RandOKxSI low stalls issue (zero bubble on SboxInxDO); retirement is never stalled, the S-box is a fixed pipe.
//
// Ports:
//   ClkxCI, RstxBI      clock, async active-low reset
//   StartxSI            start a pass (accepted in IDLE only)
//   StatexDI/StatexDO   shared AES state, share i at [128i+127:128i], byte k at [128i+8k+7:128i+8k]
//   RandOKxSI           S-box randomness valid; gates issue
//   SboxInxDO           shared byte to the S-box (share i at [8i+7:8i]), zero on bubbles
//   SboxOutxDI          shared S-box result, LATENCY cycles after the issue
//   BusyxSO, DonexSO    high in RUN / one-cycle pulse in DONE
module masked_subbytes_seq #(
    parameter int unsigned SHARES  = 2,
    parameter int unsigned LATENCY = 5
) (
    input  logic                    ClkxCI,
    input  logic                    RstxBI,
    input  logic                    StartxSI,
    input  logic [128*SHARES-1:0]   StatexDI,
    input  logic                    RandOKxSI,
    output logic [8*SHARES-1:0]     SboxInxDO,
    input  logic [8*SHARES-1:0]     SboxOutxDI,
    output logic [128*SHARES-1:0]   StatexDO,
    output logic                    BusyxSO,
    output logic                    DonexSO
);

    // Packed views matching the flat port layout: [share][byte][bit].
    typedef logic [SHARES-1:0][15:0][7:0] shared_state_t;
    typedef logic [SHARES-1:0][7:0]       shared_byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [4:0]         iss_cnt_q, iss_cnt_d;
    logic [4:0]         ret_cnt_q, ret_cnt_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    shared_state_t      st_q, st_d;

    shared_byte_t       sbox_in;
    shared_byte_t       sbox_out;
    logic               issue;
    logic               retire;

    assign sbox_out = SboxOutxDI;

    // Issue stops once all 16 bytes are out; RandOKxSI is don't-care after that.
    assign issue  = (fsm_q == RUN) && RandOKxSI && !iss_cnt_q[4];
    assign retire = (fsm_q == RUN) && vld_q[LATENCY-1];

    // Read of byte IssCnt sees the register value before any same-cycle
    // retire write, and RetCnt <= IssCnt keeps unissued bytes intact.
    always_comb begin
        sbox_in = '0;
        if (issue) begin
            for (int i = 0; i < int'(SHARES); i++) begin
                sbox_in[i] = st_q[i][iss_cnt_q[3:0]];
            end
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        iss_cnt_d = iss_cnt_q;
        ret_cnt_d = ret_cnt_q;
        vld_d     = vld_q;
        st_d      = st_q;

        case (fsm_q)
            IDLE: begin
                if (StartxSI) begin
                    fsm_d     = RUN;
                    st_d      = StatexDI;
                    iss_cnt_d = '0;
                    ret_cnt_d = '0;
                    vld_d     = '0;
                end
            end

            RUN: begin
                // Valid pipe tracks which S-box pipeline slots carry real bytes.
                vld_d = (vld_q << 1) | LATENCY'(issue);
                if (issue) begin
                    iss_cnt_d = iss_cnt_q + 5'd1;
                end
                if (retire) begin
                    for (int i = 0; i < int'(SHARES); i++) begin
                        st_d[i][ret_cnt_q[3:0]] = sbox_out[i];
                    end
                    ret_cnt_d = ret_cnt_q + 5'd1;
                    if (ret_cnt_q == 5'd15) begin
                        fsm_d = DONE;
                    end
                end
            end

            DONE: begin
                fsm_d = IDLE;
            end

            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            fsm_q     <= IDLE;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
            vld_q     <= '0;
            st_q      <= '0;
        end else begin
            fsm_q     <= fsm_d;
            iss_cnt_q <= iss_cnt_d;
            ret_cnt_q <= ret_cnt_d;
            vld_q     <= vld_d;
            st_q      <= st_d;
        end
    end

    assign SboxInxDO = sbox_in;
    assign StatexDO  = st_q;
    assign BusyxSO   = (fsm_q == RUN);
    assign DonexSO   = (fsm_q == DONE);

endmodule

// File: tb/tb_masked_subbytes_seq.sv
// Bench for masked_subbytes_seq: random shared states through a behavioural masked S-box, checked against an unmasked SubBytes reference.
// Latency: each pass is expected to finish at 17+LATENCY+stalls cycles after the start edge.
// Backpressure: RandOKxSI is driven low in chosen or random issue cycles; bubbles must show a zero S-box input.
module tb_masked_subbytes_seq;

    localparam int SHARES  = 2;
    localparam int LATENCY = 5;
    localparam int W       = 128 * SHARES;

    logic               ClkxCI;
    logic               RstxBI;
    logic               StartxSI;
    logic [W-1:0]       StatexDI;
    logic               RandOKxSI;
    logic [8*SHARES-1:0] SboxInxDO;
    logic [8*SHARES-1:0] SboxOutxDI;
    logic [W-1:0]       StatexDO;
    logic               BusyxSO;
    logic               DonexSO;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;

    masked_subbytes_seq #(.SHARES(SHARES), .LATENCY(LATENCY)) dut (
        .ClkxCI     (ClkxCI),
        .RstxBI     (RstxBI),
        .StartxSI   (StartxSI),
        .StatexDI   (StatexDI),
        .RandOKxSI  (RandOKxSI),
        .SboxInxDO  (SboxInxDO),
        .SboxOutxDI (SboxOutxDI),
        .StatexDO   (StatexDO),
        .BusyxSO    (BusyxSO),
        .DonexSO    (DonexSO)
    );

    initial ClkxCI = 1'b0;
    always #5 ClkxCI = ~ClkxCI;

    always @(posedge ClkxCI) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // AES S-box from its definition: GF(2^8) inverse then affine map.
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (gmul(x, 8'(b)) == 8'h01) inv = 8'(b);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Random Boolean split of x; each mask is nonzero and differs from x.
    function automatic logic [8*SHARES-1:0] split(input logic [7:0] x);
        logic [8*SHARES-1:0] v;
        logic [7:0] acc;
        logic [7:0] r;
        v = '0; acc = 8'h00;
        for (int i = 1; i < SHARES; i++) begin
            r = 8'($urandom_range(255, 1));
            while (r == x) r = 8'($urandom_range(255, 1));
            v[8*i +: 8] = r;
            acc = acc ^ r;
        end
        v[7:0] = x ^ acc;
        return v;
    endfunction

    function automatic logic [7:0] unmask8(input logic [8*SHARES-1:0] v);
        logic [7:0] u;
        u = 8'h00;
        for (int i = 0; i < SHARES; i++) u = u ^ v[8*i +: 8];
        return u;
    endfunction

    function automatic logic [127:0] unmask128(input logic [W-1:0] v);
        logic [127:0] u;
        u = '0;
        for (int i = 0; i < SHARES; i++) u = u ^ v[128*i +: 128];
        return u;
    endfunction

    function automatic logic [127:0] subbytes_ref(input logic [127:0] x);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_f(x[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [W-1:0] share_state(input logic [127:0] x);
        logic [W-1:0] v;
        logic [8*SHARES-1:0] sh;
        for (int k = 0; k < 16; k++) begin
            sh = split(x[8*k +: 8]);
            for (int i = 0; i < SHARES; i++) v[128*i + 8*k +: 8] = sh[8*i +: 8];
        end
        return v;
    endfunction

    // ---------------- behavioural masked S-box, LATENCY deep ----------------
    logic [8*SHARES-1:0] sb_pipe [LATENCY];

    always @(posedge ClkxCI) begin
        sb_pipe[0] <= split(sbox_f(unmask8(SboxInxDO)));
        for (int j = 1; j < LATENCY; j++) sb_pipe[j] <= sb_pipe[j-1];
    end
    assign SboxOutxDI = sb_pipe[LATENCY-1];

    // ---------------- one SubBytes pass ----------------
    // mode 0: RandOKxSI always 1; 1: low in cycles T+3, T+7, T+12; 2: random.
    task automatic run_pass(input logic [W-1:0] din, input int mode, input int busy_start_at,
                            input bit hold_start, input bit check_mask,
                            output int done_off, output int done_abs);
        int issued;
        int stalls;
        logic ok;
        logic [7:0] ux;
        logic [8*SHARES-1:0] exp_in;
        issued = 0; stalls = 0; done_off = -1; done_abs = -1;

        @(negedge ClkxCI);
        StartxSI  = 1'b1;
        StatexDI  = din;
        RandOKxSI = 1'($urandom_range(1));
        @(posedge ClkxCI);

        for (int c = 1; c <= 200 && done_off < 0; c++) begin
            @(negedge ClkxCI);
            StartxSI = hold_start || (c == busy_start_at);
            if (c == busy_start_at) StatexDI = ~din;
            if (issued < 16) begin
                case (mode)
                    0:       ok = 1'b1;
                    1:       ok = !(c == 3 || c == 7 || c == 12);
                    default: ok = ($urandom_range(3) != 0);
                endcase
            end else begin
                ok = 1'($urandom_range(1));
            end
            RandOKxSI = ok;
            #1;
            if (DonexSO) begin
                done_off = c;
                done_abs = cyc_cnt;
                check("busy_in_done", BusyxSO, 0);
            end else begin
                check("busy_in_run", BusyxSO, 1);
            end
            if (issued < 16 && ok) begin
                for (int i = 0; i < SHARES; i++) exp_in[8*i +: 8] = din[128*i + 8*issued +: 8];
                check("sbox_in", SboxInxDO, exp_in);
                if (check_mask) begin
                    ux = unmask8(SboxInxDO);
                    for (int i = 0; i < SHARES; i++)
                        check("share_not_unmasked", SboxInxDO[8*i +: 8] == ux, 0);
                end
                issued++;
            end else begin
                check("sbox_in_bubble", SboxInxDO, 0);
                if (issued < 16) stalls++;
            end
        end

        if (done_off < 0) begin
            check("done_timeout", 0, 1);
        end else begin
            check("done_cycle", done_off, 17 + LATENCY + stalls);
            check("result", unmask128(StatexDO), subbytes_ref(unmask128(din)));
        end
    endtask

    // ---------------- main sequence ----------------
    logic [7:0]   aes_lit [16] = '{8'h63, 8'h7C, 8'h77, 8'h7B, 8'hF2, 8'h6B, 8'h6F, 8'hC5,
                                   8'h30, 8'h01, 8'h67, 8'h2B, 8'hFE, 8'hD7, 8'hAB, 8'h76};
    logic [127:0] lit_vec;
    logic [127:0] plain_nom;
    logic [W-1:0] din_nom;
    logic [W-1:0] held;
    int off, abs1, abs2;

    initial begin
        RstxBI = 1'b0; StartxSI = 1'b0; StatexDI = '0; RandOKxSI = 1'b0;
        for (int k = 0; k < 16; k++) begin
            plain_nom[8*k +: 8] = 8'(k);
            lit_vec[8*k +: 8]   = aes_lit[k];
        end
        din_nom = '0;
        din_nom[127:0] = plain_nom;

        // reset values with inputs active
        StartxSI = 1'b1; RandOKxSI = 1'b1; StatexDI = ~din_nom;
        repeat (3) @(negedge ClkxCI);
        #1;
        check("rst_state", StatexDO, 0);
        check("rst_sbox_in", SboxInxDO, 0);
        check("rst_busy", BusyxSO, 0);
        check("rst_done", DonexSO, 0);
        StartxSI = 1'b0;
        @(negedge ClkxCI);
        RstxBI = 1'b1;

        // nominal pass
        run_pass(din_nom, 0, -1, 0, 0, off, abs1);
        check("nominal_t22", off, 22);
        check("nominal_aes_vector", unmask128(StatexDO), lit_vec);

        // result held after DONE, start low, RandOK toggling
        held = StatexDO;
        for (int c = 0; c < 4; c++) begin
            @(negedge ClkxCI);
            StartxSI = 1'b0; RandOKxSI = 1'($urandom_range(1)); #1;
            check("hold_state", StatexDO, held);
            check("hold_done", DonexSO, 0);
            check("hold_busy", BusyxSO, 0);
        end

        // random masking of the same plaintext
        run_pass(share_state(plain_nom), 0, -1, 0, 1, off, abs1);
        check("masked_result", unmask128(StatexDO), lit_vec);

        // three stall cycles
        run_pass(share_state(plain_nom), 1, -1, 0, 1, off, abs1);
        check("stall_t25", off, 25);

        // start pulse while busy is ignored
        run_pass(din_nom, 0, 5, 0, 0, off, abs1);
        check("busy_start_t22", off, 22);
        check("busy_start_result", unmask128(StatexDO), lit_vec);

        // reset in the middle of a pass
        @(negedge ClkxCI);
        StartxSI = 1'b1; StatexDI = share_state(plain_nom);
        @(posedge ClkxCI);
        for (int c = 1; c < 10; c++) begin
            @(negedge ClkxCI);
            StartxSI = 1'b0; RandOKxSI = 1'b1; #1;
            check("pre_abort_done", DonexSO, 0);
        end
        @(negedge ClkxCI);
        RstxBI = 1'b0; #1;
        check("abort_state", StatexDO, 0);
        check("abort_busy", BusyxSO, 0);
        check("abort_sbox_in", SboxInxDO, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge ClkxCI); #1;
            check("abort_no_done", DonexSO, 0);
            check("abort_state_held", StatexDO, 0);
        end
        @(negedge ClkxCI);
        RstxBI = 1'b1;
        run_pass(din_nom, 0, -1, 0, 0, off, abs1);
        check("after_abort_t22", off, 22);

        // back-to-back with start held high
        run_pass(share_state($urandom() ^ {$urandom(), 96'h0}), 0, -1, 1, 1, off, abs1);
        run_pass(share_state({$urandom(), $urandom(), $urandom(), $urandom()}), 0, -1, 0, 1, off, abs2);
        check("b2b_spacing", abs2 - abs1, 23);

        // random data and random stalls
        for (int t = 0; t < 6; t++) begin
            run_pass(share_state({$urandom(), $urandom(), $urandom(), $urandom()}), 2, -1, 0, 1, off, abs1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
